// File: rtl/clock_freq_meter_pkg.sv
`timescale 1ns / 1ps
// Shared types and constants for the clock frequency meter.
package clock_freq_meter_pkg;

  // Reference-domain sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GATE    = 2'b01,
    ST_DRAIN   = 2'b10,
    ST_CAPTURE = 2'b11
  } state_t;

  // Depth of every clock-domain-crossing synchroniser.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/clock_freq_meter_if.sv
`timescale 1ns / 1ps
// Request/result bundle of the clock frequency meter.
interface clock_freq_meter_if
  import clock_freq_meter_pkg::*;
#(
  parameter int CNT_W = 24
);
  logic             start;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             dead;

  // Requester side: issues start, observes the result.
  modport master (
    output start,
    input  busy, valid, count, overflow, dead
  );

  // Meter side: receives start, drives the result.
  modport slave (
    input  start,
    output busy, valid, count, overflow, dead
  );
endinterface

// File: rtl/clock_freq_meter_sync2.sv
`timescale 1ns / 1ps
// Multi-flop synchroniser with asynchronous active-low clear.
module sync2
  import clock_freq_meter_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [SYNC_STAGES-1:0][W-1:0] pipe;

  // Shift the asynchronous input through the chain; clear on reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[SYNC_STAGES-2:0], d};
    end
  end

  assign q = pipe[SYNC_STAGES-1];
endmodule

// File: rtl/clock_freq_meter.sv
`timescale 1ns / 1ps
// Gated edge counter: counts mclk rising edges over GATE_CYCLES CLK periods.
// The count crosses back as a quasi-static bus once the ack handshake
// shows the mclk domain has stopped counting.
module clock_freq_meter
  import clock_freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 100000,
  parameter int CNT_W       = 24
) (
  input  logic CLK,
  input  logic RESET,
  input  logic mclk,
  clock_freq_meter_if.slave bus
);
  localparam int               TMR_W    = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

  // Reference domain
  state_t           state, state_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic             seen, seen_nx;
  logic             capture;
  logic             en;
  logic             ack_s;
  logic             busy_q, valid_q, ovf_q, dead_q;
  logic [CNT_W-1:0] count_q;

  // mclk domain
  logic             rst_m;
  logic             en_m;
  logic             ack;
  logic [CNT_W-1:0] cnt_m;
  logic             ovf_m;

  // Sequencer next-state: open the gate, wait for the mclk side to stop, capture.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    seen_nx  = seen;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx = ST_GATE;
          timer_nx = TMR_LOAD;
          seen_nx  = 1'b0;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_GATE: begin
        if (ack_s) begin
          seen_nx = 1'b1;
        end else begin
          seen_nx = seen;
        end
        if (timer == '0) begin
          state_nx = ST_DRAIN;
        end else begin
          timer_nx = timer - TMR_W'(1);
        end
      end
      ST_DRAIN: begin
        // A dead mclk never raises ack, so there is nothing to wait for.
        if (!seen) begin
          state_nx = ST_CAPTURE;
        end else if (!ack_s) begin
          state_nx = ST_CAPTURE;
        end else begin
          state_nx = ST_DRAIN;
        end
      end
      ST_CAPTURE: begin
        capture  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, gate timer and activity flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
      timer <= '0;
      seen  <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      seen  <= seen_nx;
    end
  end

  // Registered gate enable and result outputs; results move only on valid.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      en      <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      en      <= (state_nx == ST_GATE);
      busy_q  <= (state_nx != ST_IDLE);
      valid_q <= capture;
      if (capture && seen) begin
        count_q <= cnt_m;
        ovf_q   <= ovf_m;
        dead_q  <= 1'b0;
      end else if (capture) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
        dead_q  <= 1'b1;
      end else begin
        count_q <= count_q;
        ovf_q   <= ovf_q;
        dead_q  <= dead_q;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.dead     = dead_q;

  // mclk-domain reset: asserts with RESET, releases after two mclk edges.
  sync2 #(.W(1)) u_rst_sync (
    .clk   (mclk),
    .clr_n (RESET),
    .d     (1'b1),
    .q     (rst_m)
  );

  sync2 #(.W(1)) u_en_sync (
    .clk   (mclk),
    .clr_n (rst_m),
    .d     (en),
    .q     (en_m)
  );

  // Edge counter: clear when the gate opens, count while open, saturate at all-ones.
  always_ff @(posedge mclk or negedge rst_m) begin
    if (!rst_m) begin
      ack   <= 1'b0;
      cnt_m <= '0;
      ovf_m <= 1'b0;
    end else begin
      ack <= en_m;
      if (en_m && !ack) begin
        cnt_m <= '0;
        ovf_m <= 1'b0;
      end else if (en_m && (&cnt_m)) begin
        ovf_m <= 1'b1;
      end else if (en_m) begin
        cnt_m <= cnt_m + CNT_W'(1);
      end else begin
        cnt_m <= cnt_m;
      end
    end
  end

  sync2 #(.W(1)) u_ack_sync (
    .clk   (CLK),
    .clr_n (RESET),
    .d     (ack),
    .q     (ack_s)
  );
endmodule

// File: tb/tb_clock_freq_meter.sv
`timescale 1ns / 1ps
// Self-checking bench for clock_freq_meter: directed scenarios with random
// mclk periods, checked against an ideal-frequency reference model.
module tb_clock_freq_meter;
  localparam int  GATE   = 1000;
  localparam real T_CLK  = 10.0;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  logic mclk  = 1'b0;
  real  mclk_half = 20.0;
  bit   mclk_run  = 1'b1;

  int checks = 0;
  int errors = 0;

  int vcnt_a    = 0;
  int hold_viol = 0;
  logic [23:0] prev_cnt_a = '0;

  clock_freq_meter_if #(.CNT_W(24)) bus_a ();
  clock_freq_meter_if #(.CNT_W(8))  bus_b ();

  clock_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(24)) dut_a (
    .CLK(CLK), .RESET(RESET), .mclk(mclk), .bus(bus_a)
  );

  clock_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(8)) dut_b (
    .CLK(CLK), .RESET(RESET), .mclk(mclk), .bus(bus_b)
  );

  always #5 CLK = ~CLK;

  // Clock under measurement; parked low while stopped.
  always begin
    if (mclk_run) begin
      #(mclk_half);
      mclk = ~mclk;
    end else begin
      mclk = 1'b0;
      #1;
    end
  end

  // Count valid pulses and catch result changes outside the valid cycle.
  always @(negedge CLK) begin
    if (bus_a.valid) vcnt_a <= vcnt_a + 1;
    if (RESET && !bus_a.valid && (bus_a.count !== prev_cnt_a)) hold_viol <= hold_viol + 1;
    prev_cnt_a <= bus_a.count;
  end

  // Ideal edge count for a gate of GATE reference periods.
  function automatic real ideal_count(input real period);
    return real'(GATE) * T_CLK / period;
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input real expv, input real tol);
    checks++;
    assert ((real'(obs) >= expv - tol) && (real'(obs) <= expv + tol)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%f+-%f", tag, obs, expv, tol);
    end
  endtask

  // One start pulse, then wait (bounded) for valid. Optionally re-pulse start mid-gate.
  task automatic measure(input bit sel_b, input bit hammer,
                         output int cnt, output bit ovf, output bit dd, output int cyc,
                         output bit busy_first, output bit busy_at_valid, output bit timed_out);
    bit got;
    bit st;
    got = 1'b0; timed_out = 1'b0; cyc = 0; cnt = 0; ovf = 1'b0; dd = 1'b0;
    busy_first = 1'b0; busy_at_valid = 1'b0;
    @(negedge CLK);
    if (sel_b) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    while (!got && !timed_out) begin
      @(negedge CLK);
      cyc++;
      st = hammer && (cyc < 990) && ((cyc % 37) == 0);
      if (sel_b) bus_b.start = st; else bus_a.start = st;
      if (cyc == 1) busy_first = sel_b ? bus_b.busy : bus_a.busy;
      if (sel_b ? bus_b.valid : bus_a.valid) begin
        got = 1'b1;
        cnt = sel_b ? int'(bus_b.count) : int'(bus_a.count);
        ovf = sel_b ? bus_b.overflow : bus_a.overflow;
        dd  = sel_b ? bus_b.dead : bus_a.dead;
        busy_at_valid = sel_b ? bus_b.busy : bus_a.busy;
      end else if (cyc >= 4000) begin
        timed_out = 1'b1;
      end
    end
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  int  cnt, cyc, vbefore;
  bit  ovf, dd, bf, bv, to;
  int  rep [3];
  real period;

  initial begin
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (5) @(negedge CLK);
    check("reset_a", {bus_a.busy, bus_a.valid, bus_a.overflow, bus_a.dead, bus_a.count}, 0);
    check("reset_b", {bus_b.busy, bus_b.valid, bus_b.overflow, bus_b.dead, bus_b.count}, 0);
    RESET = 1'b1;
    repeat (5) @(negedge CLK);

    // 40 ns mclk
    measure(1'b0, 1'b0, cnt, ovf, dd, cyc, bf, bv, to);
    check("t40_timeout", to, 0);
    check_near("t40_count", cnt, ideal_count(40.0), 2.0);
    check("t40_ovf", ovf, 0);
    check("t40_dead", dd, 0);
    check("t40_busy_after_start", bf, 1);
    check("t40_busy_at_valid", bv, 0);

    // 7 ns mclk, three repeats
    mclk_half = 3.5;
    repeat (10) @(negedge CLK);
    for (int r = 0; r < 3; r++) begin
      measure(1'b0, 1'b0, cnt, ovf, dd, cyc, bf, bv, to);
      check("t7_timeout", to, 0);
      check_near("t7_count", cnt, ideal_count(7.0), 2.0);
      rep[r] = cnt;
    end
    check_near("t7_repeat1", rep[1], real'(rep[0]), 2.0);
    check_near("t7_repeat2", rep[2], real'(rep[0]), 2.0);

    // Random periods
    for (int i = 0; i < 4; i++) begin
      period = 8.0 + real'($urandom_range(0, 7200)) / 100.0;
      mclk_half = period / 2.0;
      repeat (10) @(negedge CLK);
      measure(1'b0, 1'b0, cnt, ovf, dd, cyc, bf, bv, to);
      check("rand_timeout", to, 0);
      check_near("rand_count", cnt, ideal_count(period), 2.0);
      check("rand_dead", dd, 0);
    end

    // Dead mclk
    mclk_run = 1'b0;
    repeat (10) @(negedge CLK);
    measure(1'b0, 1'b0, cnt, ovf, dd, cyc, bf, bv, to);
    check("dead_valid_latency", cyc, GATE + 3);
    check("dead_count", cnt, 0);
    check("dead_flag", dd, 1);
    check("dead_ovf", ovf, 0);
    check("dead_busy_at_valid", bv, 0);
    repeat (3) @(negedge CLK);
    check("dead_busy_after", bus_a.busy, 0);

    // Saturation on the 8-bit instance
    mclk_half = 2.5;
    mclk_run  = 1'b1;
    repeat (10) @(negedge CLK);
    measure(1'b1, 1'b0, cnt, ovf, dd, cyc, bf, bv, to);
    check("sat_timeout", to, 0);
    check("sat_count", cnt, 255);
    check("sat_ovf", ovf, 1);
    check("sat_dead", dd, 0);
    mclk_half = 20.0;
    repeat (10) @(negedge CLK);
    measure(1'b1, 1'b0, cnt, ovf, dd, cyc, bf, bv, to);
    check_near("b40_count", cnt, ideal_count(40.0), 2.0);
    check("b40_ovf", ovf, 0);

    // start hammered while busy
    vbefore = vcnt_a;
    measure(1'b0, 1'b1, cnt, ovf, dd, cyc, bf, bv, to);
    check("hammer_timeout", to, 0);
    check_near("hammer_count", cnt, ideal_count(40.0), 2.0);
    repeat (1200) @(negedge CLK);
    check("hammer_single_valid", vcnt_a - vbefore, 1);
    check("hammer_idle_after", bus_a.busy, 0);

    // RESET mid-gate
    @(negedge CLK);
    bus_a.start = 1'b1;
    @(negedge CLK);
    bus_a.start = 1'b0;
    repeat (500) @(negedge CLK);
    check("mid_busy_before_reset", bus_a.busy, 1);
    vbefore = vcnt_a;
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check("mid_reset_outputs", {bus_a.busy, bus_a.valid, bus_a.overflow, bus_a.dead, bus_a.count}, 0);
    RESET = 1'b1;
    repeat (1200) @(negedge CLK);
    check("mid_no_valid_after", vcnt_a - vbefore, 0);
    check("mid_busy_after", bus_a.busy, 0);
    measure(1'b0, 1'b0, cnt, ovf, dd, cyc, bf, bv, to);
    check("mid_timeout", to, 0);
    check_near("mid_count", cnt, ideal_count(40.0), 2.0);
    check("mid_dead", dd, 0);

    check("result_hold", hold_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_freq_meter.md
# clock_freq_meter

Measures the frequency of an arbitrary clock `mclk` against the board clock `CLK`. A start pulse opens a gate of `GATE_CYCLES` `CLK` periods, and the block reports how many `mclk` rising edges fell inside that gate. It sits beside the clock/reset generator and checks that the PLL or divided design clock really runs at the intended rate, for example for display over UART/LEDs.

## Interface
Parameters:
- `GATE_CYCLES`, default 100000: gate length in `CLK` cycles; must be ≥ 16.
- `CNT_W`, default 24: width of the `mclk` edge counter and of `count`.

Ports:
- `CLK`: in, 1, reference clock. All ports except `mclk` belong to this domain.
- `RESET`: in, 1. Asynchronous, active-low, for both domains.
- `mclk`: in, 1, clock under measurement; may be stopped.
- `start`: in, 1, one-cycle request; sampled only in `IDLE`.
- `busy`: out, 1, high from the cycle after an accepted `start` until `valid`.
- `valid`: out, 1, one-cycle pulse when the result is updated.
- `count`: out, `CNT_W`, `mclk` edges counted in the last gate; holds between measurements.
- `overflow`: out, 1, the edge counter saturated during the last gate.
- `dead`: out, 1, no `mclk` activity was seen during the last gate.

## Operation
`CLK` domain FSM (`IDLE`, `GATE`, `DRAIN`, `CAPTURE`):
- `IDLE`: `en`=0.
  - If `start`=1, go to `GATE`, load gate timer = `GATE_CYCLES`-1, clear `seen`.
- `GATE`: `en`=1 and the timer decrements.
  - `seen` is set once `ack_s`=1.
  - At timer 0, go to `DRAIN`.
- `DRAIN`: `en`=0.
  - If `seen`=0, go to `CAPTURE` at once (`mclk` is dead).
  - Otherwise wait for `ack_s`=0, then go to `CAPTURE`.
- `CAPTURE`:
  - If `seen`=1: `count` ← mclk counter, `overflow` ← mclk ovf flag, `dead` ← 0.
  - If `seen`=0: `count` ← 0, `overflow` ← 0, `dead` ← 1.
  - Pulse `valid` and return to `IDLE`.

`mclk` domain:
- `en` passes through a 2-flop synchroniser to give `en_m`.
- On the rising edge of `en_m`, the counter clears to 0 and the ovf flag clears.
- While `en_m`=1, the counter increments; at all-ones it holds and sets ovf.
- `ack` = `en_m`, registered once. It is synchronised back to `CLK` by 2 flops to give `ack_s`.

Reset and clock-domain crossing rules:
- Release of `RESET` into the `mclk` domain goes through a local reset synchroniser: asynchronous assert, release after 2 `mclk` edges.
- The counter value crosses the domain as a quasi-static bus. It is sampled only in `CAPTURE`, after `ack_s`=0 has been observed; it cannot change again until the next `en` rise.

Boundary cases:
- `start` while busy is ignored, with no queuing.
- `start` in the `CAPTURE` cycle is ignored.
- `RESET` asserted mid-operation: FSM goes to `IDLE`, all outputs go to 0, and the `mclk` domain clears asynchronously. The next `start` after release measures normally.
- `mclk` stopping mid-gate:
  - If it stops before `ack_s` rises: report `dead`=1.
  - If it stops after `ack_s` rises, the FSM waits in `DRAIN` indefinitely.
  - `RESET` is the only recovery from a `DRAIN` hang. This is accepted and documented.

## Timing
- Reset value of every output: 0.
- `start` at edge t: `busy`=1 and `en`=1 from t+1.
  - `en` falls at t+1+`GATE_CYCLES`.
- `valid` pulse comes 1 cycle after `ack_s`=0 is seen.
  - This is roughly 3 `mclk` + 3 `CLK` cycles after `en` falls.
  - `busy` falls in the same cycle that `valid` is asserted.
- `dead` case: `valid` at t+`GATE_CYCLES`+3.
- Synchroniser latencies at start and stop are symmetric.
  - Accuracy: `count` = `GATE_CYCLES`·f_mclk/f_CLK ± 2.
- `count`, `overflow` and `dead` change only in the `valid` cycle.

## Structure
- Shared package: FSM state encoding (2 bits) and the `SYNC_STAGES`=2 constant.
- Sub-module `sync2`: 2-flop synchroniser with asynchronous active-low clear, parameterised width.
  - Used for `en`, `ack`, and the `mclk`-domain reset-release synchroniser.
- All logic fits in one file plus `sync2`.

## Test plan
- `GATE_CYCLES`=1000, `CLK` 10 ns, `mclk` 40 ns, `start` pulse → `valid` once, `count` 250±2, `overflow`=0, `dead`=0.
- Same setup with `mclk` 7 ns → `count` 1428±2. Repeat the measurement 3 times; each result is within ±2 of the others.
- `mclk` held at 0 → `valid` at t+1003, `count`=0, `dead`=1, `busy` 0 afterwards.
- `CNT_W`=8, `mclk` 5 ns, `GATE_CYCLES`=1000 → `count`=255, `overflow`=1.
- `start` asserted repeatedly while `busy`=1 → exactly one `valid`, and the result matches a single measurement.
- `RESET` low mid-`GATE` for 3 cycles → all outputs 0, `busy` 0. A new `start` yields a correct `count` (250±2 at 40 ns).
